// File: rtl/mdu_unit.sv
// RV32M multiply/divide unit for the EX stage: single-cycle-latency multiply,
// 32-step restoring divide, registered result/tag with a one-cycle DONE pulse.
module mdu_unit #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       FUNCT3,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  input  logic [RD_W-1:0]  RD_IN,
  input  logic             FLUSH,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [RD_W-1:0]  RD_OUT
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_funct3;
  logic [RD_W-1:0]  r_rd;
  logic [WIDTH:0]   r_a, r_b;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg, r_r_neg;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [RD_W-1:0]  r_rd_out;

  logic             w_a_signed, w_b_signed, w_div_signed;
  logic [WIDTH:0]   w_a_ext, w_b_ext;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic             w_div_zero, w_div_ovf;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH+1:0] w_shift, w_dvsr;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_q_fix, w_r_fix;

  // MULHSU treats OPA as signed and OPB as unsigned; MULHU neither.
  assign w_div_signed = ~FUNCT3[0];
  assign w_a_signed   = FUNCT3[2] ? w_div_signed : (FUNCT3[1:0] != 2'b11);
  assign w_b_signed   = FUNCT3[2] ? w_div_signed : ~FUNCT3[1];
  assign w_a_ext      = {w_a_signed & OPA[WIDTH-1], OPA};
  assign w_b_ext      = {w_b_signed & OPB[WIDTH-1], OPB};
  assign w_a_mag      = (w_div_signed & OPA[WIDTH-1]) ? (~OPA + ONE) : OPA;
  assign w_b_mag      = (w_div_signed & OPB[WIDTH-1]) ? (~OPB + ONE) : OPB;
  assign w_div_zero   = (OPB == '0);
  assign w_div_ovf    = w_div_signed & (OPA == MIN_NEG) & (OPB == '1);

  assign w_prod = {{(WIDTH-1){r_a[WIDTH]}}, r_a} * {{(WIDTH-1){r_b[WIDTH]}}, r_b};

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_dvsr     = {1'b0, r_b};
  assign w_ge       = (w_shift >= w_dvsr);
  assign w_rem_next = (WIDTH+1)'(w_ge ? (w_shift - w_dvsr) : w_shift);

  assign w_q_fix = r_q_neg ? (~r_quo + ONE) : r_quo;
  assign w_r_fix = r_r_neg ? (~r_rem[WIDTH-1:0] + ONE) : r_rem[WIDTH-1:0];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    if (FLUSH) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (START) begin
          if (!FUNCT3[2])                  w_next = S_MUL;
          else if (w_div_zero || w_div_ovf) w_next = S_FIX;
          else                              w_next = S_DIV;
        end
        S_MUL:  w_next = S_IDLE;
        S_DIV:  if (r_cnt == CNT_MAX) w_next = S_FIX;
        S_FIX:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_funct3 <= '0;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      r_done <= 1'b0;
      if (FLUSH) begin
        r_cnt <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: if (START) begin
            r_funct3 <= FUNCT3;
            r_rd     <= RD_IN;
            r_a      <= w_a_ext;
            r_b      <= w_b_ext;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_rem    <= '0;
            if (FUNCT3[2]) begin
              if (w_div_zero) begin
                r_quo <= '1;
                r_rem <= {1'b0, OPA};
              end else if (w_div_ovf) begin
                r_quo <= MIN_NEG;
              end else begin
                // Divide on magnitudes; signs are reapplied in FIX.
                r_a     <= {1'b0, w_a_mag};
                r_b     <= {1'b0, w_b_mag};
                r_quo   <= w_a_mag;
                r_q_neg <= w_div_signed & (OPA[WIDTH-1] ^ OPB[WIDTH-1]);
                r_r_neg <= w_div_signed & OPA[WIDTH-1];
              end
            end
          end
          S_MUL: begin
            r_result <= (r_funct3 == 3'b000) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
            r_rd_out <= r_rd;
            r_done   <= 1'b1;
          end
          S_DIV: begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CNT_ONE;
          end
          S_FIX: begin
            r_result <= r_funct3[1] ? w_r_fix : w_q_fix;
            r_rd_out <= r_rd;
            r_done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign BUSY   = (r_state != S_IDLE);
  assign DONE   = r_done;
  assign RESULT = r_result;
  assign RD_OUT = r_rd_out;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table plus flush/reset/ignored-start
// sequences, with a scoreboard queue checked whenever DONE pulses.
module tb_mdu_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START = 1'b0;
  logic        FLUSH = 1'b0;
  logic [2:0]  FUNCT3 = '0;
  logic [31:0] OPA = '0, OPB = '0;
  logic [4:0]  RD_IN = '0;
  logic        BUSY, DONE;
  logic [31:0] RESULT;
  logic [4:0]  RD_OUT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] exp;
    logic [4:0]  rd;
    int          k;
    int          lat;
  } sb_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  sb_t sb_q[$];

  mdu_unit #(.WIDTH(32), .RD_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
    .OPA(OPA), .OPB(OPB), .RD_IN(RD_IN), .FLUSH(FLUSH),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .RD_OUT(RD_OUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin : monitor
    sb_t e;
    if (DONE === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: DONE=1 RESULT %h with no op outstanding (cycle %0d)", RESULT, cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", RESULT, e.exp);
        check("rd_out", 32'(RD_OUT), 32'(e.rd));
        check("latency", 32'(cyc - e.k), 32'(e.lat));
      end
    end
  end

  // Drive one START pulse; the accepting edge is the next rising edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat,
                       input bit accept);
    FUNCT3 = f;
    OPA    = a;
    OPB    = b;
    RD_IN  = rd;
    START  = 1'b1;
    if (accept) sb_q.push_back('{exp, rd, cyc + 1, lat});
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic drain(output int n_busy);
    n_busy = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (BUSY) n_busy++;
      if (sb_q.size() == 0) return;
      @(negedge CLK);
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d results outstanding, want 0", sb_q.size());
    sb_q.delete();
  endtask

  initial begin : main
    vec_t vecs[21];
    int nb;
    int d;

    vecs = '{
      '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1},
      '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1},
      '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1},
      '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1},
      '{3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 1},
      '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1},
      '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33},
      '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33},
      '{3'b101, 32'h00000064, 32'h00000007, 32'h0000000E, 33},
      '{3'b111, 32'h00000064, 32'h00000007, 32'h00000002, 33},
      '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33},
      '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33},
      '{3'b100, 32'h80000000, 32'h00000001, 32'h80000000, 33},
      '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33},
      '{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1},
      '{3'b110, 32'h00000005, 32'h00000000, 32'h00000005, 1},
      '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
      '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
      '{3'b111, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1},
      '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33},
      '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33}
    };

    RESET = 1'b1;
    #2 RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_result", RESULT, 32'd0);
    check("rst_rd_out", 32'(RD_OUT), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);

    // Each vector is issued in the DONE cycle of the previous one.
    for (int i = 0; i < 21; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat, 1'b1);
      drain(nb);
      check("busy_cycles", 32'(nb), 32'(vecs[i].lat));
    end

    // START during an active divide must not disturb it.
    issue(3'b101, 32'd100, 32'd7, 5'd22, 32'd14, 33, 1'b1);
    repeat (5) @(negedge CLK);
    FUNCT3 = 3'b111; OPA = 32'd9; OPB = 32'd4; RD_IN = 5'd3; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    drain(nb);
    d = done_cnt;
    repeat (5) @(negedge CLK);
    check("ignored_start_no_done", 32'(done_cnt), 32'(d));

    // Flush at divide iteration 10.
    issue(3'b101, 32'd100, 32'd7, 5'd23, 32'd0, 0, 1'b0);
    repeat (10) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    #1;
    check("flush_busy", 32'(BUSY), 32'd0);
    check("flush_result_held", RESULT, 32'd14);
    check("flush_rd_held", 32'(RD_OUT), 32'd22);
    d = done_cnt;
    repeat (40) @(negedge CLK);
    check("flush_no_done", 32'(done_cnt), 32'(d));

    // Flush on the completing edge of a multiply.
    issue(3'b000, 32'd3, 32'd5, 5'd24, 32'd0, 0, 1'b0);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    #1;
    check("flush_complete_busy", 32'(BUSY), 32'd0);
    check("flush_complete_result", RESULT, 32'd14);

    // FLUSH together with START in IDLE drops the request.
    FLUSH = 1'b1;
    issue(3'b000, 32'd3, 32'd5, 5'd25, 32'd0, 0, 1'b0);
    FLUSH = 1'b0;
    #1;
    check("flush_start_busy", 32'(BUSY), 32'd0);
    d = done_cnt;
    repeat (3) @(negedge CLK);
    check("flush_start_no_done", 32'(done_cnt), 32'(d));

    issue(3'b000, 32'd3, 32'd5, 5'd26, 32'd15, 1, 1'b1);
    drain(nb);

    // Asynchronous reset in the middle of a divide.
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd27, 32'd0, 0, 1'b0);
    repeat (10) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_done", 32'(DONE), 32'd0);
    check("midrst_result", RESULT, 32'd0);
    check("midrst_rd_out", 32'(RD_OUT), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    d = done_cnt;
    repeat (40) @(negedge CLK);
    check("midrst_no_done", 32'(done_cnt), 32'(d));
    check("midrst_idle", 32'(BUSY), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- RV32M multiply/divide unit in the EX stage.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- RESULT is a registered 32-bit value that feeds the writeback-select mux as its ALU-side input.
- Multiply is fixed-latency. Divide is an iterative 32-step restoring divider.
- BUSY is driven to the hazard unit so it can stall the front of the pipeline.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported.
- RD_W, 5, destination-register tag width.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-low reset
- START  input  1  request pulse; sampled only in IDLE
- FUNCT3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- OPA  input  32  rs1 value
- OPB  input  32  rs2 value
- RD_IN  input  5  destination tag
- FLUSH  input  1  synchronous abort
- BUSY  output  1  high while state != IDLE (combinational from state)
- DONE  output  1  registered one-cycle valid pulse
- RESULT  output  32  registered result; held until the next completion
- RD_OUT  output  5  tag of the completed op; updates together with RESULT

Behaviour:
- Reset (RESET low, asynchronous):
  - state=IDLE, DONE=0, RESULT=0, RD_OUT=0.
  - Counter and internal operand registers cleared.
  - Reset mid-operation aborts the op with no DONE.
- States: IDLE, MUL, DIV, FIX.
- Timing reference: edge k is the edge that samples START=1 in IDLE.
- Start in IDLE:
  - Latch FUNCT3, RD_IN and operands.
  - Operands are sign- or zero-extended to 33 bits per op (MULHSU: OPA signed, OPB unsigned).
- MUL path:
  - IDLE->MUL at edge k.
  - At edge k+1: 64-bit product formed; RESULT = low 32 (MUL) or high 32 (MULH/MULHSU/MULHU); DONE=1; ->IDLE.
  - Latency: 1 cycle after acceptance.
- DIV path, normal:
  - IDLE->DIV at edge k. Latch |OPA| and |OPB| (signed ops only); record the quotient sign and the remainder sign (sign of dividend). Counter=0.
  - Edges k+1..k+32: one restoring step per edge (shift remainder:quotient left 1, trial subtract, set quotient bit).
  - At the edge where counter==31, go to FIX.
  - Edge k+33: negate quotient/remainder as recorded; RESULT = quotient (DIV/DIVU) or remainder (REM/REMU); DONE=1; ->IDLE.
- DIV special cases (detected at acceptance; IDLE->FIX at edge k; DONE at edge k+1):
  - OPB==0: quotient = 0xFFFFFFFF, remainder = OPA (signed and unsigned alike).
  - Signed DIV/REM with OPA=0x80000000 and OPB=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- DONE:
  - High for exactly one cycle, coincident with the new RESULT/RD_OUT.
  - BUSY is already low in that cycle, so a START in the DONE cycle is accepted (back-to-back issue).
- START while BUSY is ignored: no queuing, latched operands unchanged.
- FLUSH:
  - Synchronous. At the next edge, state->IDLE, counter cleared, no DONE.
  - RESULT/RD_OUT keep their previous values.
  - FLUSH and START together in IDLE: FLUSH wins and the request is dropped.
  - FLUSH on the completing edge: the completion is suppressed (DONE=0, RESULT unchanged).
- Arithmetic:
  - All internal multiply/divide datapaths are 33/64 bits wide, with no truncation before the final select.
  - Negation is two's complement modulo 2^32.

Test Plan:
- Reset asserted during a DIV at iteration 10:
  - Outputs go to 0 immediately.
  - BUSY=0; no DONE after release.
- MUL 7 x 0xFFFFFFFD:
  - RESULT=0xFFFFFFEB, DONE at edge k+1, RD_OUT=RD_IN.
- MULH 0x80000000 x 0x80000000:
  - RESULT=0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF:
  - RESULT=0xFFFFFFFE.
- MULHSU OPA=0xFFFFFFFF, OPB=0xFFFFFFFF:
  - RESULT=0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2:
  - RESULT=0xFFFFFFFD, DONE at edge k+33, BUSY high for 33 cycles.
- REM with the same operands:
  - RESULT=0xFFFFFFFF.
  - Issue it in the DONE cycle of the DIV to confirm back-to-back acceptance.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
  - Each with DONE at edge k+1.
- Flush and ignored START:
  - DIVU 100/7 with FLUSH at iteration 10: BUSY low next cycle, no DONE, RESULT unchanged.
  - START asserted during an active DIV (no FLUSH) is ignored; the DIV result is unaffected.
